// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg : stage encoding, stage-enable bit positions and defaults.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF    = 3'd1,
    S_ID    = 3'd2,
    S_EX    = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_FAULT = 3'd6
  } stage_e;

  localparam int STAGE_W = 5;
  localparam int EN_IF   = 0;
  localparam int EN_ID   = 1;
  localparam int EN_EX   = 2;
  localparam int EN_MEM  = 3;
  localparam int EN_WB   = 4;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  function automatic logic [STAGE_W-1:0] stage_onehot(input stage_e s);
    logic [STAGE_W-1:0] v;
    v = '0;
    case (s)
      S_IF:    v[EN_IF]  = 1'b1;
      S_ID:    v[EN_ID]  = 1'b1;
      S_EX:    v[EN_EX]  = 1'b1;
      S_MEM:   v[EN_MEM] = 1'b1;
      S_WB:    v[EN_WB]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// stage_sequencer_if : run/ack/request handshake bundle of the sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface stage_sequencer_if #(
  parameter int CNT_W = 16
);
  import seq_pkg::*;

  logic               i_run;
  logic               i_imem_ack;
  logic               i_dmem_ack;
  logic               i_is_mem;
  logic               o_imem_req;
  logic               o_dmem_req;
  logic [STAGE_W-1:0] o_stage_en;
  logic               o_pc_we;
  logic [CNT_W-1:0]   o_retired;
  logic               o_fault;

  modport master (
    input  i_run, i_imem_ack, i_dmem_ack, i_is_mem,
    output o_imem_req, o_dmem_req, o_stage_en, o_pc_we, o_retired, o_fault
  );

  modport slave (
    output i_run, i_imem_ack, i_dmem_ack, i_is_mem,
    input  o_imem_req, o_dmem_req, o_stage_en, o_pc_we, o_retired, o_fault
  );

endinterface

`default_nettype wire

// File: rtl/seq_wait_timer.sv
// ---------------------------------------------------------------------------
// seq_wait_timer : clearable memory-wait counter; limit_hit marks the cycle
// in which an enabled count reaches LIMIT.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_wait_timer #(
  parameter int LIMIT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      limit_hit
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign limit_hit = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer : IF/ID/EX/MEM/WB control FSM with memory-timeout fault.
// SEQ_SKIP_MEM_EN: non-memory instructions bypass MEM.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stage_sequencer
  import seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  stage_sequencer_if.master  bus
);

  stage_e             state;
  stage_e             nxt_state;
  logic               mem_flag;
  logic               nxt_flag;
  logic               limit_hit;
  logic               timer_en;
  logic               timer_clr;

  logic               imem_req;
  logic               dmem_req;
  logic [STAGE_W-1:0] stage_en;
  logic               pc_we;
  logic [CNT_W-1:0]   retired;
  logic               fault;

  // Timer only runs while a request is outstanding and unacknowledged, and is
  // held clear in every other state so each IF/MEM visit starts from zero.
  assign timer_en  = ((state == S_IF)  && !bus.i_imem_ack) ||
                     ((state == S_MEM) && mem_flag && !bus.i_dmem_ack);
  assign timer_clr = !((state == S_IF) || (state == S_MEM));

  seq_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (i_clk),
    .rst       (i_reset),
    .clear     (timer_clr),
    .enable    (timer_en),
    .limit_hit (limit_hit)
  );

  always_comb begin
    nxt_state = state;
    nxt_flag  = mem_flag;
    case (state)
      S_IDLE:  if (bus.i_run) nxt_state = S_IF;
      S_IF: begin
        // An ack in the limit cycle wins over the timeout.
        if (bus.i_imem_ack)  nxt_state = S_ID;
        else if (limit_hit)  nxt_state = S_FAULT;
      end
      S_ID:    nxt_state = S_EX;
      S_EX: begin
        nxt_flag = bus.i_is_mem;
`ifdef SEQ_SKIP_MEM_EN
        nxt_state = bus.i_is_mem ? S_MEM : S_WB;
`else
        nxt_state = S_MEM;
`endif
      end
      S_MEM: begin
        if (!mem_flag || bus.i_dmem_ack) nxt_state = S_WB;
        else if (limit_hit)              nxt_state = S_FAULT;
      end
      S_WB:    nxt_state = bus.i_run ? S_IF : S_IDLE;
      S_FAULT: nxt_state = S_FAULT;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      mem_flag <= 1'b0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      stage_en <= '0;
      pc_we    <= 1'b0;
      retired  <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= nxt_state;
      mem_flag <= nxt_flag;
      imem_req <= (nxt_state == S_IF);
      dmem_req <= (nxt_state == S_MEM) && nxt_flag;
      stage_en <= stage_onehot(nxt_state);
      pc_we    <= (nxt_state == S_WB);
      fault    <= (nxt_state == S_FAULT);
      if (nxt_state == S_WB) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign bus.o_imem_req = imem_req;
  assign bus.o_dmem_req = dmem_req;
  assign bus.o_stage_en = stage_en;
  assign bus.o_pc_we    = pc_we;
  assign bus.o_retired  = retired;
  assign bus.o_fault    = fault;

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer : directed checks of stage order, waits, timeout, reset
// and counter wrap.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stage_sequencer;

`ifdef SEQ_SKIP_MEM_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wrst;
  int   total = 0;
  int   bad   = 0;
  int   hi;
  int   pulses;

  stage_sequencer_if #(.CNT_W(16)) sbus ();
  stage_sequencer_if #(.CNT_W(4))  wbus ();

  stage_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (sbus)
  );

  stage_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(4)) u_wrap (
    .i_clk   (clk),
    .i_reset (wrst),
    .bus     (wbus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stage enable in cycle k (1-based) of back-to-back non-memory work.
  function automatic logic [4:0] exp_en(input int k);
    int pos;
    if (SKIP) begin
      pos = (k - 1) % 4;
      return (pos == 3) ? 5'b10000 : (5'b00001 << pos);
    end
    pos = (k - 1) % 5;
    return 5'b00001 << pos;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wrst = 1'b1;
    sbus.i_run = 1'b0;  sbus.i_imem_ack = 1'b0;
    sbus.i_dmem_ack = 1'b0;  sbus.i_is_mem = 1'b0;
    wbus.i_run = 1'b1;  wbus.i_imem_ack = 1'b1;
    wbus.i_dmem_ack = 1'b1;  wbus.i_is_mem = 1'b0;
    repeat (2) tick();

    chk("rst_stage_en", sbus.o_stage_en, 0);
    chk("rst_imem_req", sbus.o_imem_req, 0);
    chk("rst_dmem_req", sbus.o_dmem_req, 0);
    chk("rst_pc_we",    sbus.o_pc_we,    0);
    chk("rst_retired",  sbus.o_retired,  0);
    chk("rst_fault",    sbus.o_fault,    0);

    // Free-running zero-wait pipeline.
    sbus.i_run = 1'b1; sbus.i_imem_ack = 1'b1; sbus.i_dmem_ack = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("seq_stage_en", sbus.o_stage_en, exp_en(k));
      chk("seq_pc_we", sbus.o_pc_we, exp_en(k) == 5'b10000);
    end
    chk("seq_retired3", sbus.o_retired, 3);

    // Drop run during EX: instruction finishes, then park in IDLE.
    rst = 1'b1; sbus.i_is_mem = 1'b1;
    tick();
    chk("rst2_stage_en", sbus.o_stage_en, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("drop_ex", sbus.o_stage_en, 5'b00100);
    sbus.i_run = 1'b0;
    tick();
    chk("drop_mem", sbus.o_stage_en, 5'b01000);
    chk("drop_dmem_req", sbus.o_dmem_req, 1);
    tick();
    chk("drop_wb_pc_we", sbus.o_pc_we, 1);
    chk("drop_wb_retired", sbus.o_retired, 1);
    repeat (2) tick();
    chk("drop_idle", sbus.o_stage_en, 0);
    chk("drop_idle_pc_we", sbus.o_pc_we, 0);
    sbus.i_run = 1'b1;
    tick();
    chk("rerun_if", sbus.o_stage_en, 5'b00001);
    chk("rerun_imem_req", sbus.o_imem_req, 1);

    // Reset pulsed during a MEM wait; a late dmem ack must be ignored.
    sbus.i_dmem_ack = 1'b0;
    repeat (4) tick();
    chk("mw_dmem_req", sbus.o_dmem_req, 1);
    chk("mw_stage_en", sbus.o_stage_en, 5'b01000);
    chk("mw_retired", sbus.o_retired, 1);
    rst = 1'b1;
    tick();
    chk("mwrst_dmem_req", sbus.o_dmem_req, 0);
    chk("mwrst_retired", sbus.o_retired, 0);
    chk("mwrst_stage_en", sbus.o_stage_en, 0);
    rst = 1'b0; sbus.i_run = 1'b0; sbus.i_dmem_ack = 1'b1;
    repeat (2) tick();
    chk("late_ack_stage", sbus.o_stage_en, 0);
    chk("late_ack_dmem", sbus.o_dmem_req, 0);
    chk("late_ack_pc_we", sbus.o_pc_we, 0);
    chk("late_ack_retired", sbus.o_retired, 0);

    // Data access acked after three wait cycles: request high for four.
    sbus.i_run = 1'b1; sbus.i_dmem_ack = 1'b0;
    repeat (3) tick();
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sbus.o_dmem_req === 1'b1) hi++;
    end
    chk("dwait_req_cycles", hi, 4);
    sbus.i_dmem_ack = 1'b1;
    tick();
    chk("dwait_req_drop", sbus.o_dmem_req, 0);
    chk("dwait_wb_pc_we", sbus.o_pc_we, 1);
    chk("dwait_retired", sbus.o_retired, 1);

    // Fetch never acked: 16 request cycles, then sticky fault.
    rst = 1'b1;
    tick();
    rst = 1'b0; sbus.i_imem_ack = 1'b0;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (sbus.o_imem_req === 1'b1) hi++;
    end
    chk("to_req_cycles", hi, 16);
    chk("to_no_fault_yet", sbus.o_fault, 0);
    tick();
    chk("to_fault", sbus.o_fault, 1);
    chk("to_stage_en", sbus.o_stage_en, 0);
    chk("to_imem_req", sbus.o_imem_req, 0);
    sbus.i_imem_ack = 1'b1;
    repeat (3) tick();
    chk("to_sticky", sbus.o_fault, 1);
    chk("to_sticky_stage", sbus.o_stage_en, 0);
    rst = 1'b1;
    tick();
    chk("to_rst_clear", sbus.o_fault, 0);

    // Ack arriving in the 16th wait cycle beats the timeout.
    rst = 1'b0; sbus.i_imem_ack = 1'b0;
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (sbus.o_imem_req === 1'b1) hi++;
    end
    chk("ack16_req_cycles", hi, 16);
    sbus.i_imem_ack = 1'b1;
    tick();
    chk("ack16_id", sbus.o_stage_en, 5'b00010);
    chk("ack16_no_fault", sbus.o_fault, 0);
    tick();
    chk("ack16_ex", sbus.o_stage_en, 5'b00100);

    // 4-bit retired counter wraps after 16 retirements.
    wrst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 200 && pulses < 16; c++) begin
      tick();
      if (wbus.o_pc_we === 1'b1) begin
        pulses++;
        if (pulses == 15) chk("wrap_15", wbus.o_retired, 15);
        if (pulses == 16) chk("wrap_0", wbus.o_retired, 0);
      end
    end
    chk("wrap_pulses", pulses, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum cycles waiting for a memory ack before fault; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset; sampled on i_clk rising edge.
REQ-005 i_run  input  1  level: 1 = fetch next instruction; 0 = park in IDLE after current instruction.
REQ-006 i_imem_ack  input  1  instruction memory completion, sampled while o_imem_req=1.
REQ-007 i_dmem_ack  input  1  data memory completion, sampled while o_dmem_req=1.
REQ-008 i_is_mem  input  1  decoded instruction accesses data memory; sampled in EX only.
REQ-009 o_imem_req  output  1  instruction fetch request.
REQ-010 o_dmem_req  output  1  data access request.
REQ-011 o_stage_en  output  5  one-hot stage enable {WB,MEM,EX,ID,IF}; all zero in IDLE/FAULT.
REQ-012 o_pc_we  output  1  PC write strobe, one cycle per retired instruction.
REQ-013 o_retired  output  CNT_W  retired-instruction count.
REQ-014 o_fault  output  1  memory-timeout fault, sticky.

Function
REQ-015 FSM states SHALL be IDLE, IF, ID, EX, MEM, WB, FAULT; all outputs registered-state decodes (Moore), except none.
REQ-016 IDLE: i_run=1 -> IF next cycle; else stay.
REQ-017 IF: o_stage_en[0]=1, o_imem_req=1; held until i_imem_ack=1, then ID next cycle; zero-wait ack -> IF lasts exactly one cycle.
REQ-018 ID and EX SHALL each last exactly one cycle; EX latches i_is_mem into an internal flag.
REQ-019 MEM: if flag=1, o_dmem_req=1 held until i_dmem_ack, then WB; if flag=0, one cycle, o_dmem_req=0, then WB.
REQ-020 WB: one cycle, o_pc_we=1, o_retired increments by 1 wrapping 2^CNT_W-1 -> 0; next state IF if i_run=1, else IDLE.
REQ-021 i_run deassertion outside WB/IDLE SHALL NOT abort the instruction in flight.
REQ-022 Wait timer clears on entry to IF/MEM and counts each cycle a request is outstanding without ack; reaching TIMEOUT_CYCLES -> FAULT next cycle.
REQ-023 Ack in the same cycle the timer reaches TIMEOUT_CYCLES: ack wins, no fault.
REQ-024 Acks arriving while the matching request is low SHALL be ignored.
REQ-025 FAULT: o_fault=1, all other outputs 0 (o_retired holds); exit only via i_reset.
REQ-026 Minimum latency per non-memory instruction with zero-wait fetch: 5 cycles IF-to-WB inclusive (macro off).

Reset
REQ-027 i_reset=1 SHALL, at the next edge, force state IDLE, o_fault=0, o_retired=0, wait timer=0, mem flag=0; all outputs 0 from the following cycle, including mid-handshake (requests drop, pending acks ignored).

Configuration
REQ-028 Macro SEQ_SKIP_MEM_EN defined: EX with i_is_mem=0 goes directly to WB (4-cycle minimum latency); EX with i_is_mem=1 unchanged.
REQ-029 Macro undefined: every instruction visits MEM per REQ-019.

Structure
REQ-030 Package seq_pkg SHALL hold the stage_e state enum, one-hot stage-enable bit index constants, and the default TIMEOUT_CYCLES.
REQ-031 Sub-module seq_wait_timer SHALL implement the clearable, enabled wait counter with a limit-reached flag; FSM remains in stage_sequencer.

Verification
REQ-032 Reset, i_run=1, acks tied 1, macro off -> o_stage_en cycles 00001,00010,00100,01000,10000 repeatedly; o_pc_we every 5th cycle; o_retired=3 after 15 cycles.
REQ-033 Same, macro on, i_is_mem=0 -> MEM skipped, o_pc_we every 4th cycle; i_is_mem=1 with dmem ack after 3 wait cycles -> o_dmem_req high exactly 4 cycles.
REQ-034 i_imem_ack held 0, TIMEOUT_CYCLES=16 -> o_imem_req high 16 cycles, then o_fault=1 and o_stage_en=0 until reset; ack on cycle 16 instead -> ID, no fault.
REQ-035 i_run dropped during EX -> instruction completes WB, then IDLE; i_run reasserted -> IF next cycle.
REQ-036 i_reset pulsed during MEM wait -> o_dmem_req=0 next cycle, o_retired=0, state IDLE; late i_dmem_ack ignored.
REQ-037 CNT_W=4, 16 retirements from reset -> o_retired wraps 15 -> 0.
